// File: rtl/keypad_if.sv
// Keypad-side bundle: row sense lines in, column drives and decoded key results out.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [7:0] entry;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_down,
        output entry
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  entry
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column multiplexing, per-scan classification, debounce FSM
// and a two-nibble entry shift register.
module keypad_scanner #(
    parameter int CLK_FREQ       = 12000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);
    localparam int             STEP_CLKS = CLK_FREQ / SCAN_HZ;
    localparam int             TW        = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(STEP_CLKS - 1);
    localparam logic [3:0]     DS        = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Row-major keypad legend; row 3 carries * (E), 0, # (F), D.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_r, row_sync_r;
    logic [TW-1:0] tick_cnt_r;
    logic          tick_s, eval_s;
    logic [3:0]    col_r;
    logic [1:0]    col_idx_r;
    logic [1:0]    acc_hits_r;
    logic [3:0]    acc_code_r;
    logic [2:0]    col_hits_s, scan_hits_s;
    logic [3:0]    col_code_s, scan_code_s;
    logic          scan_none_s, scan_single_s;
    state_t        state_r, state_nxt;
    logic [3:0]    cnt_r, cnt_nxt, cnt_inc_s;
    logic [3:0]    cand_r, cand_nxt;
    logic          accept_s, release_s;
    logic [3:0]    key_code_r;
    logic          key_valid_r, key_down_r;
    logic [7:0]    entry_r;

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign eval_s    = tick_s && (col_idx_r == 2'd3);
    assign cnt_inc_s = cnt_r + 4'd1;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= kp.row;
            row_sync_r <= row_meta_r;
        end
    end

    // Step divider and column rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
            col_r      <= 4'b1110;
            col_idx_r  <= 2'd0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
            col_r      <= {col_r[2:0], col_r[3]};
            col_idx_r  <= col_idx_r + 2'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Keys seen in the active column merged with what earlier columns of this scan found.
    always_comb begin
        col_hits_s = 3'd0;
        col_code_s = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_r[r]) begin
                col_hits_s = col_hits_s + 3'd1;
                col_code_s = key_map(2'(r), col_idx_r);
            end else begin
                col_hits_s = col_hits_s;
            end
        end
        scan_hits_s   = {1'b0, acc_hits_r} + col_hits_s;
        scan_code_s   = (acc_hits_r != 2'd0) ? acc_code_r : col_code_s;
        scan_none_s   = (scan_hits_s == 3'd0);
        scan_single_s = (scan_hits_s == 3'd1);
    end

    // Per-scan accumulator, saturating at 2 (meaning "several keys").
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'h0;
        end else if (eval_s) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'h0;
        end else if (tick_s) begin
            acc_hits_r <= (scan_hits_s >= 3'd2) ? 2'd2 : scan_hits_s[1:0];
            acc_code_r <= scan_code_s;
        end else begin
            acc_hits_r <= acc_hits_r;
            acc_code_r <= acc_code_r;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            cand_r  <= 4'h0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            cand_r  <= cand_nxt;
        end
    end

    // Debounce FSM transitions; only a completed scan can move it.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        cand_nxt  = cand_r;
        accept_s  = 1'b0;
        release_s = 1'b0;
        if (eval_s) begin
            case (state_r)
                IDLE: begin
                    if (scan_single_s) begin
                        cand_nxt = scan_code_s;
                        if (DS == 4'd1) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = 4'd0;
                            accept_s  = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                            cnt_nxt   = 4'd1;
                        end
                    end else begin
                        cnt_nxt = 4'd0;
                    end
                end
                DEBOUNCE: begin
                    if (scan_single_s && (scan_code_s == cand_r)) begin
                        if (cnt_inc_s >= DS) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = 4'd0;
                            accept_s  = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc_s;
                        end
                    end else if (scan_single_s) begin
                        cand_nxt = scan_code_s;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (scan_none_s && (DS == 4'd1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                        release_s = 1'b1;
                    end else if (scan_none_s) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = 4'd1;
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                RELEASE: begin
                    if (scan_none_s && (cnt_inc_s >= DS)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                        release_s = 1'b1;
                    end else if (scan_none_s) begin
                        cnt_nxt = cnt_inc_s;
                    end else begin
                        state_nxt = PRESSED;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Acceptance / release side effects, one clock after the evaluating tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
            entry_r     <= 8'h00;
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= cand_nxt;
                entry_r    <= {entry_r[3:0], cand_nxt};
                key_down_r <= 1'b1;
            end else if (release_s) begin
                key_down_r <= 1'b0;
            end else begin
                key_down_r <= key_down_r;
            end
        end
    end

    assign kp.col       = col_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_down  = key_down_r;
    assign kp.entry     = entry_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows from a set of held keys,
// and a scan-level reference model predicts every pulse, code and entry value.
module tb_keypad_scanner;
    localparam int CLK_FREQ  = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int DS        = 4;
    localparam int SCAN_CLKS = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mask = 16'h0000;
    logic [3:0]  row_v;

    keypad_if kif ();

    keypad_scanner #(
        .CLK_FREQ      (CLK_FREQ),
        .SCAN_HZ       (SCAN_HZ),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_v = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (kif.col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (mask[r*4+c]) row_v[r] = 1'b0;
                end
            end
        end
    end
    assign kif.row = row_v;

    logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int checks = 0;
    int errors = 0;
    int obs_pulses = 0;
    int exp_pulses = 0;

    bit         m_held;
    int         m_run;
    int         m_rel;
    logic [3:0] m_cand;
    logic [3:0] m_code;
    logic [7:0] m_entry;
    bit         m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] key_bit(input logic [3:0] code);
        logic [15:0] b;
        b = 16'h0000;
        for (int i = 0; i < 16; i++) if (key_tab[i] == code) b = 16'h0001 << i;
        return b;
    endfunction

    task automatic model_reset();
        m_held = 0; m_run = 0; m_rel = 0;
        m_cand = 4'h0; m_code = 4'h0; m_entry = 8'h00; m_pulse = 0;
    endtask

    // One whole scan of a fixed key set, judged by the debounce rules.
    task automatic model_scan(input logic [15:0] m);
        int         n;
        logic [3:0] k;
        n = $countones(m);
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (m[i]) k = key_tab[i];
        m_pulse = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_cand) m_run++;
                else begin m_cand = k; m_run = 1; end
                if (m_run >= DS) begin
                    m_held = 1; m_run = 0; m_rel = 0; m_code = k;
                    m_entry = {m_entry[3:0], k};
                    m_pulse = 1;
                    exp_pulses++;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel >= DS) begin m_held = 0; m_rel = 0; end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] m, input string tag);
        int early;
        early = 0;
        mask = m;
        model_scan(m);
        repeat (SCAN_CLKS - 1) begin
            @(posedge clk); #1;
            if (kif.key_valid) early++;
        end
        @(posedge clk); #1;
        obs_pulses += early + int'(kif.key_valid);
        check({tag, "_stray_valid"}, early, 0);
        check({tag, "_key_valid"}, kif.key_valid, m_pulse);
        check({tag, "_key_down"}, kif.key_down, m_held);
        check({tag, "_key_code"}, kif.key_code, m_code);
        check({tag, "_entry"}, kif.entry, m_entry);
    endtask

    task automatic run_scans(input logic [15:0] m, input int n, input string tag);
        for (int i = 0; i < n; i++) run_scan(m, tag);
    endtask

    initial begin
        int base;
        int cyc_valid;
        logic [15:0] m;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_col", kif.col, 4'b1110);
        check("reset_entry", kif.entry, 8'h00);
        check("reset_valid", kif.key_valid, 1'b0);
        check("reset_down", kif.key_down, 1'b0);
        check("reset_code", kif.key_code, 4'h0);

        @(negedge clk) rst_n = 1'b1;
        cyc_valid = 0;
        repeat (9) begin @(posedge clk); #1; cyc_valid += int'(kif.key_valid); end
        check("rot_col_hold", kif.col, 4'b1110);
        @(posedge clk); #1;
        cyc_valid += int'(kif.key_valid);
        check("rot_col_step", kif.col, 4'b1101);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midcount_reset_col", kif.col, 4'b1110);
        check("reset_no_pulse", cyc_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        // Clean press of "5" then release.
        base = obs_pulses;
        run_scans(key_bit(4'h5), 8, "clean");
        check("clean_code", kif.key_code, 4'h5);
        check("clean_entry", kif.entry, 8'h05);
        run_scans(16'h0000, 3, "clean_rel");
        check("clean_still_down", kif.key_down, 1'b1);
        run_scan(16'h0000, "clean_rel4");
        check("clean_released", kif.key_down, 1'b0);
        check("clean_pulses", obs_pulses - base, 1);

        // Two-key entry "A" then "3".
        base = obs_pulses;
        run_scans(key_bit(4'hA), 5, "two_a");
        run_scans(16'h0000, 5, "two_rel_a");
        run_scans(key_bit(4'h3), 5, "two_3");
        run_scans(16'h0000, 5, "two_rel_3");
        check("two_entry", kif.entry, 8'hA3);
        check("two_code", kif.key_code, 4'h3);
        check("two_pulses", obs_pulses - base, 2);

        // Bouncing "9".
        base = obs_pulses;
        for (int i = 0; i < 10; i++)
            run_scan((i % 2 == 0) ? key_bit(4'h9) : 16'h0000, "bounce");
        check("bounce_pulses", obs_pulses - base, 0);
        check("bounce_entry", kif.entry, 8'hA3);
        check("bounce_down", kif.key_down, 1'b0);

        // "1" and "2" together, then "1" alone.
        base = obs_pulses;
        run_scans(key_bit(4'h1) | key_bit(4'h2), 6, "multi");
        check("multi_none", obs_pulses - base, 0);
        run_scans(key_bit(4'h1), 4, "multi_single");
        check("multi_code", kif.key_code, 4'h1);
        check("multi_pulses", obs_pulses - base, 1);
        run_scans(16'h0000, 5, "multi_rel");

        // Long hold of "F" with a short release glitch.
        base = obs_pulses;
        run_scans(key_bit(4'hF), 20, "hold");
        run_scans(16'h0000, 2, "hold_glitch");
        run_scans(key_bit(4'hF), 3, "hold_again");
        check("hold_down", kif.key_down, 1'b1);
        check("hold_pulses", obs_pulses - base, 1);
        run_scans(16'h0000, 5, "hold_rel");

        // Random key activity against the model.
        for (int seg = 0; seg < 40; seg++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) m = 16'h0000;
            else if (sel < 8) m = 16'h0001 << $urandom_range(0, 15);
            else m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            run_scans(m, $urandom_range(1, 6), "rand");
        end
        check("rand_pulse_total", obs_pulses, exp_pulses);

        // Reset while a key is held.
        run_scans(key_bit(4'h7), 5, "pre_reset");
        repeat (7) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midop_entry", kif.entry, 8'h00);
        check("midop_down", kif.key_down, 1'b0);
        check("midop_code", kif.key_code, 4'h0);
        check("midop_col", kif.col, 4'b1110);
        mask = 16'h0000;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        base = obs_pulses;
        run_scans(16'h0000, 3, "post_reset");
        check("post_reset_pulses", obs_pulses - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment output path. Where the display path time-multiplexes a common line and decodes a nibble to segments, this block does the reverse.
- Time-multiplexes the columns of a 4x4 hex keypad, reads the rows and debounces the result. Encodes one key to a 4-bit nibble and shifts it into an 8-bit entry byte.
- The entry byte feeds the FeatherWing display path in place of the DIP switches.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- SCAN_HZ, 1000, column step rate in Hz. One full scan takes 4 steps.
- DEBOUNCE_SCANS, 4, number of consecutive identical full scans needed to accept a press or a release. Legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- row  input  4  keypad row inputs, active-low (pulled up externally). Asynchronous to clk.
- col  output  4  column drives, active-low, one-hot-zero.
- key_code  output  4  nibble of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_down  output  1  high while the accepted key is considered held.
- entry  output  8  shift register of the last two accepted nibbles.

Behaviour:
- Synchroniser: row passes through a 2-flop synchroniser before use. Reset value 4'b1111.
- Step tick:
  - Counter counts 0..(CLK_FREQ/SCAN_HZ - 1) and raises an internal tick on the terminal count, then wraps to 0.
- Column drive:
  - On reset col = 4'b1110 (column 0 active).
  - On each tick: sample the synchronised row for the current column, then rotate col left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- Key encoding:
  - Row r low while column c is active means key (r,c) is down.
  - Map, row-major: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
- Scan result, evaluated on the tick that samples column 3:
  - NONE: no keys down.
  - SINGLE(code): exactly one key down across all 4 columns.
  - MULTI: two or more keys down.
  - The per-scan accumulators clear after evaluation.
- FSM states IDLE, DEBOUNCE, PRESSED, RELEASE. 4-bit counter cnt; candidate register cand.
  - IDLE:
    - SINGLE(k) -> DEBOUNCE, cand = k, cnt = 1.
    - When DEBOUNCE_SCANS = 1, SINGLE(k) goes directly to PRESSED with acceptance.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt + 1. When cnt reaches DEBOUNCE_SCANS -> PRESSED with acceptance.
    - SINGLE(other k) -> cand = k, cnt = 1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - NONE -> RELEASE, cnt = 1 (or straight to IDLE if DEBOUNCE_SCANS = 1).
    - SINGLE (any code) or MULTI -> stay. No rollover and no autorepeat.
  - RELEASE:
    - NONE -> cnt + 1. When cnt reaches DEBOUNCE_SCANS -> IDLE and key_down = 0.
    - SINGLE or MULTI -> PRESSED. cnt is cleared and nothing is re-accepted.
- Acceptance actions, registered in the cycle after the evaluating tick:
  - key_code = cand.
  - entry = {entry[3:0], cand}.
  - key_valid = 1 for exactly one clk.
  - key_down = 1.
- Reset values: col = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, entry = 8'h00, state IDLE, cnt = 0, tick counter = 0.
- Reset mid-operation: asserting rst_n low at any point returns all of the above to reset values immediately. No key_valid pulse on deassertion.
- Latency:
  - A clean press is accepted DEBOUNCE_SCANS full scans after the first scan that sees it.
  - key_valid fires 1 clk after the column-3 tick of the last qualifying scan.
  - Row synchroniser latency (2 clk) is absorbed by the tick sampling. row must be stable at least 3 clk before the tick.

Test Plan:
- Settings for all scenarios: CLK_FREQ = 1000, SCAN_HZ = 100 (10 clk per step, 40 clk per scan), DEBOUNCE_SCANS = 4.
- Reset: hold rst_n = 0 mid-count, then release -> col = 1110, entry = 00, key_valid never pulses. col then rotates to 1101 exactly 10 clk after release.
- Clean press: model key "5" (row1 low while col1 active) held for 8 scans -> one key_valid pulse, key_code = 5, entry = 8'h05, key_down = 1. On release, key_down falls after 4 NONE scans.
- Two-key entry: press and release "A", then "3" -> entry = 8'hA3, exactly two key_valid pulses, key_code = 3.
- Bounce: key "9" present on alternating scans for 10 scans -> no key_valid, state returns to IDLE, entry unchanged.
- Multi-key: hold "1" and "2" together for 6 scans -> no acceptance. Then release "2" with "1" still held for 4 scans -> key_code = 1, single key_valid.
- Hold / re-press: hold "F" for 20 scans -> one pulse only. A 2-scan release glitch, then the key is down again -> no new pulse and key_down stays 1.
